ahb_fetch_master: RTL and testbench
===================================

# ahb_fetch_master

- AHB-Lite read-only master that fetches 32-bit instruction words from the instruction memory slave and buffers them for the decode stage.
- Sits directly upstream of the memory slave on the AHB bus and directly upstream of decode via a valid/ready interface.
- Issues pipelined single-word reads at a sequential PC and holds fetched words with their PC in a small FIFO.
- Handles slave wait states, redirects (branch/jump flush) and error responses.

## Interface
Parameters:
- FIFO_DEPTH, 4: instruction buffer entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset; word aligned.

Ports (reset is asynchronous, active-low):
- HCLK  in  1  bus/system clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  out  32  address-phase address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11; BUSY never driven.
- HWRITE  out  1  constant 0.
- HSIZE  out  3  constant 3'b010 (word).
- HWDATA  out  32  constant 0.
- HRDATA  in  32  read data, sampled when HREADY=1 in data phase.
- HREADY  in  1  transfer complete / address accepted.
- HRESP  in  2  00 OKAY, 01 ERROR.
- redirect_valid  in  1  one-cycle request to restart fetch.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0).
- instr_valid  out  1  FIFO head valid.
- instr_data  out  32  FIFO head instruction.
- instr_pc  out  32  FIFO head PC.
- instr_ready  in  1  decode accepts head when instr_valid & instr_ready.
- fetch_err  out  1  one-cycle pulse on ERROR response.

## Operation
- FSM states:
  - S_IDLE: no transfer outstanding.
  - S_ADDR: address phase only.
  - S_DATA: data phase only; HTRANS=IDLE.
  - S_PIPE: data phase N plus address phase N+1.
  - S_HALT: stopped after an error.
- All transitions occur only on edges where HREADY=1. With HREADY=0, HADDR/HTRANS are held stable.
- Issue rule: a new address phase is started only if fifo_count + outstanding ≤ FIFO_DEPTH−1, where outstanding counts the data phase not yet pushed. Pops in the same cycle are not credited.
- HREADY=1 in S_ADDR → S_PIPE if the issue rule holds, else S_DATA.
- HREADY=1 in S_PIPE or S_DATA:
  - Push {pc_of_phase, HRDATA} into the FIFO.
  - Fetch PC advances by 4 per accepted address; 32-bit wrap (FFFF_FFFC → 0000_0000).
  - Next state: S_PIPE if issued and the rule holds again; S_ADDR or S_DATA accordingly; S_IDLE if nothing is outstanding.
- S_IDLE moves to S_ADDR as soon as the issue rule holds.
- Redirect:
  - FIFO flushed on the redirect_valid edge; instr_valid is 0 from the next cycle.
  - Target latched; a later redirect before it is applied overwrites it (last wins).
  - Applied at the next HREADY=1 edge, or immediately in S_IDLE/S_HALT.
  - Any data completing on that edge is discarded.
  - An address accepted on that edge marks its data phase as drop: no push, no error reporting.
  - The next address phase is NONSEQ at the target.
  - A redirect arriving on the same edge as a push/pop wins: FIFO ends empty.
- Error: HRESP=ERROR at data-phase completion →
  - No push; fetch_err pulses.
  - Any pipelined address is abandoned (HTRANS=IDLE next cycle).
  - → S_HALT. Only redirect leaves S_HALT; FIFO contents remain poppable.
- FIFO: simultaneous push and pop allowed when full or empty; the pop-on-empty request is ignored.

## Timing
- Reset values:
  - Bus outputs: HADDR=0, HTRANS=IDLE, HWRITE=0, HSIZE=3'b010, HWDATA=0.
  - Decode side: instr_valid=0, instr_data=0, instr_pc=0, fetch_err=0.
  - Internal: PC=RESET_PC, state S_IDLE.
- First cycle after reset release: S_IDLE → address phase RESET_PC driven in cycle 1.
- Zero-wait slave:
  - Data completes at the end of cycle 2.
  - instr_valid=1 in cycle 3.
  - Sustained rate: 1 word/cycle.
- Each slave wait state (HREADY=0) adds one cycle.
- Redirect to first valid target instruction with a zero-wait slave: 3 cycles from application.

## Configuration
- FETCH_SEQ_BURST_EN defined:
  - An address phase issued in S_PIPE, continuing consecutive PCs with no intervening redirect, is driven as SEQ.
  - The first address after reset, redirect, idle or halt is NONSEQ.
- Undefined: every address phase is NONSEQ. No other behaviour changes.

## Structure
- Package fetch_pkg holds:
  - htrans_t
  - fetch_state_t
  - HSIZE_WORD
  - HRESP_OKAY / HRESP_ERROR
  - the NOP encoding shared with memory
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr}, parameter DEPTH.
  - Ports: push, pop, flush, count, full, empty; head data registered.

## Test plan
- Reset, zero-wait slave holding mem[0..3]=11,22,33,44 with instr_ready=1:
  - HADDR 0,4,8,C on consecutive cycles.
  - Words with PCs 0..C appear back-to-back from cycle 3.
- instr_ready=0, FIFO_DEPTH=4: exactly 4 words fetched, then HTRANS=IDLE; a single pop releases exactly one new fetch.
- Redirect to 0x40 while a transfer is stalled with HREADY=0:
  - HADDR held until HREADY=1, then NONSEQ 0x40.
  - Stale word never delivered; next instr_pc=0x40.
- HRESP=ERROR on address 0x8:
  - fetch_err one pulse; words 0x0, 0x4 still delivered; no bus activity.
  - Redirect to 0x0 restarts fetch.
- With FETCH_SEQ_BURST_EN: sequential run shows NONSEQ then SEQ. Without the macro: all NONSEQ.
- Async HRESETn assertion mid-burst: all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared AHB-Lite and fetch-buffer types for the
// instruction fetch master and the instruction memory slave.
package fetch_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_PIPE,
      S_HALT
   } fetch_state_t;

   localparam logic [2:0]  HSIZE_WORD  = 3'b010;
   localparam logic [1:0]  HRESP_OKAY  = 2'b00;
   localparam logic [1:0]  HRESP_ERROR = 2'b01;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ahb_fetch_master_if.sv
// AHB-Lite bus bundle and fetch-to-decode valid/ready bundle
// used by ahb_fetch_master.
interface ahb_lite_if;
   import fetch_pkg::*;

   logic [31:0] HADDR;
   htrans_t     HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic [1:0]  HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

interface fetch_dec_if;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_ready;

   modport master (
      output instr_valid, instr_data, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  instr_valid, instr_data, instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, instr} buffer with a registered head
// entry; flush has priority over push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  din,
   output fetch_entry_t  dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   fetch_entry_t   r_mem [DEPTH];
   fetch_entry_t   r_head;
   logic [AW-1:0]  r_rd;
   logic [AW-1:0]  r_wr;
   logic [CW-1:0]  r_cnt;

   logic           w_pop;
   logic           w_push;
   logic [AW-1:0]  w_rd_n;
   logic [CW-1:0]  w_cnt_pop;

   assign w_pop     = pop & (r_cnt != '0);
   assign w_push    = push & ((r_cnt != CW'(DEPTH)) | w_pop);
   assign w_rd_n    = r_rd + AW'(w_pop);
   assign w_cnt_pop = r_cnt - CW'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push && !flush)
         r_mem[r_wr] <= din;
   end

   // Head tracks the next entry; a push into an emptied buffer bypasses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd   <= '0;
         r_wr   <= '0;
         r_cnt  <= '0;
         r_head <= '0;
      end else if (flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         r_rd  <= w_rd_n;
         r_wr  <= r_wr + AW'(w_push);
         r_cnt <= w_cnt_pop + CW'(w_push);
         if (w_cnt_pop != '0)
            r_head <= r_mem[w_rd_n];
         else if (w_push)
            r_head <= din;
      end
   end

   assign dout  = r_head;
   assign count = r_cnt;
   assign full  = (r_cnt == CW'(DEPTH));
   assign empty = (r_cnt == '0);

endmodule

// File: rtl/ahb_fetch_master.sv
// ahb_fetch_master: pipelined AHB-Lite instruction fetch with buffer.
// Define FETCH_SEQ_BURST_EN to drive back-to-back pipelined fetches as SEQ.
module ahb_fetch_master
   import fetch_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   ahb_lite_if.master        ahb,
   fetch_dec_if.master       dec,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              fetch_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t r_state;
   logic [31:0]  r_haddr;
   htrans_t      r_htrans;
   logic [31:0]  r_pc;
   logic [31:0]  r_dph_pc;
   logic         r_dph_drop;
   logic         r_rd_pend;
   logic [31:0]  r_rd_pc;
   logic         r_err;

   logic [CW-1:0] w_cnt;
   logic          w_full;
   logic          w_empty;
   fetch_entry_t  w_head;
   fetch_entry_t  w_din;
   logic [31:0]   w_rd_in;
   logic [31:0]   w_tgt;
   logic          w_redir;
   logic          w_step;
   logic          w_apply;
   logic          w_done;
   logic          w_acc;
   logic          w_err;
   logic          w_push;
   logic [CW:0]   w_need;
   logic          w_issue;
   logic          w_go;
   logic          w_fault;
   logic          w_next;
   logic          w_stop;
   htrans_t       w_cont;

   assign w_rd_in = redirect_pc & 32'hFFFF_FFFC;
   assign w_redir = redirect_valid | r_rd_pend;
   assign w_tgt   = redirect_valid ? w_rd_in : r_rd_pc;

   // Idle and halted states own no bus transfer, so they never wait.
   assign w_step  = ahb.HREADY | (r_state == S_IDLE) | (r_state == S_HALT);
   assign w_apply = w_redir & w_step;

   assign w_done = ahb.HREADY & ((r_state == S_DATA) | (r_state == S_PIPE));
   assign w_acc  = ahb.HREADY & ((r_state == S_ADDR) | (r_state == S_PIPE));

   assign w_err  = w_done & ~r_dph_drop & ~w_redir
                 & (ahb.HRESP == HRESP_ERROR);
   assign w_push = w_done & ~r_dph_drop & ~w_redir
                 & (ahb.HRESP != HRESP_ERROR);

   // Words buffered plus the data phase still owed after this edge.
   assign w_need  = (CW+1)'(w_cnt) + (CW+1)'(w_push) + (CW+1)'(w_acc);
   assign w_issue = (w_need <= (CW+1)'(FIFO_DEPTH - 1)) & ~w_full;

   assign w_go    = w_step & ~w_redir & (r_state != S_HALT);
   assign w_fault = w_go & w_err;
   assign w_next  = w_go & ~w_err & w_issue;
   assign w_stop  = w_go & ~w_err & ~w_issue;

`ifdef FETCH_SEQ_BURST_EN
   assign w_cont = w_acc ? HTRANS_SEQ : HTRANS_NONSEQ;
`else
   assign w_cont = HTRANS_NONSEQ;
`endif

   assign w_din.pc    = r_dph_pc;
   assign w_din.instr = ahb.HRDATA;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state    <= S_IDLE;
         r_haddr    <= '0;
         r_htrans   <= HTRANS_IDLE;
         r_pc       <= RESET_PC;
         r_dph_pc   <= '0;
         r_dph_drop <= 1'b0;
         r_rd_pend  <= 1'b0;
         r_rd_pc    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_err;
         if (w_apply)
            r_rd_pend <= 1'b0;
         else if (redirect_valid)
            r_rd_pend <= 1'b1;
         if (redirect_valid)
            r_rd_pc <= w_rd_in;
         if (w_acc) begin
            r_dph_pc   <= r_haddr;
            r_dph_drop <= w_apply;
         end
         unique case (1'b1)
            w_apply: begin
               r_haddr  <= w_tgt;
               r_htrans <= HTRANS_NONSEQ;
               r_pc     <= w_tgt + 32'd4;
               r_state  <= w_acc ? S_PIPE : S_ADDR;
            end
            w_fault: begin
               r_htrans <= HTRANS_IDLE;
               r_state  <= S_HALT;
            end
            w_next: begin
               r_haddr  <= r_pc;
               r_htrans <= w_cont;
               r_pc     <= r_pc + 32'd4;
               r_state  <= w_acc ? S_PIPE : S_ADDR;
            end
            w_stop: begin
               r_htrans <= HTRANS_IDLE;
               r_state  <= w_acc ? S_DATA : S_IDLE;
            end
            default: ;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .push  (w_push),
      .pop   (dec.instr_ready),
      .flush (redirect_valid),
      .din   (w_din),
      .dout  (w_head),
      .count (w_cnt),
      .full  (w_full),
      .empty (w_empty)
   );

   assign ahb.HADDR  = r_haddr;
   assign ahb.HTRANS = r_htrans;
   assign ahb.HWRITE = 1'b0;
   assign ahb.HSIZE  = HSIZE_WORD;
   assign ahb.HWDATA = '0;

   assign dec.instr_valid = ~w_empty;
   assign dec.instr_data  = w_head.instr;
   assign dec.instr_pc    = w_head.pc;

   assign fetch_err = r_err;

endmodule

// File: tb/tb_ahb_fetch_master.sv
// Directed bench for ahb_fetch_master with a small zero/stalling
// AHB-Lite memory slave and hand-derived cycle expectations.
module tb_ahb_fetch_master;
   import fetch_pkg::*;

`ifdef FETCH_SEQ_BURST_EN
   localparam logic [1:0] SEQ_EXP = 2'b11;
`else
   localparam logic [1:0] SEQ_EXP = 2'b10;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_err;

   logic        stall;
   logic        err_en;
   logic [31:0] err_addr;
   logic        dp_v;
   logic [31:0] dp_a;
   logic [31:0] mem [64];
   int          n_chk = 0;
   int          n_err = 0;
   int          n_addr;

   ahb_lite_if  bus ();
   fetch_dec_if dec ();

   ahb_fetch_master dut (
      .HCLK           (HCLK),
      .HRESETn        (HRESETn),
      .ahb            (bus),
      .dec            (dec),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_err      (fetch_err)
   );

   always #5 HCLK = ~HCLK;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_v <= 1'b0;
         dp_a <= '0;
      end else if (bus.HREADY) begin
         dp_v <= bus.HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ};
         dp_a <= bus.HADDR;
      end
   end

   always_comb begin
      bus.HREADY = !(dp_v && stall);
      bus.HRDATA = dp_v ? mem[dp_a[7:2]] : NOP_INSTR;
      bus.HRESP  = (dp_v && err_en && dp_a == err_addr) ?
                   HRESP_ERROR : HRESP_OKAY;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         n_addr <= 0;
      else if (bus.HREADY && bus.HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ})
         n_addr <= n_addr + 1;
   end

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] tbl [4];
      tbl = '{32'h11, 32'h22, 32'h33, 32'h44};
      if (a[7:2] < 6'd4)
         return tbl[a[3:2]];
      return 32'hA500_0000 | {24'h0, a[7:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_haddr"},  bus.HADDR, 32'h0);
      check({tag, "_htrans"}, 32'(bus.HTRANS), 32'h0);
      check({tag, "_hwrite"}, 32'(bus.HWRITE), 32'h0);
      check({tag, "_hsize"},  32'(bus.HSIZE), 32'h2);
      check({tag, "_hwdata"}, bus.HWDATA, 32'h0);
      check({tag, "_valid"},  32'(dec.instr_valid), 32'h0);
      check({tag, "_data"},   dec.instr_data, 32'h0);
      check({tag, "_pc"},     dec.instr_pc, 32'h0);
      check({tag, "_err"},    32'(fetch_err), 32'h0);
   endtask

   task automatic hold_reset();
      HRESETn        = 1'b0;
      stall          = 1'b0;
      err_en         = 1'b0;
      err_addr       = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      dec.instr_ready = 1'b0;
      cyc(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++)
         mem[i] = exp_word(32'(i * 4));

      // Reset values, then zero-wait streaming.
      hold_reset();
      chk_reset("rst");
      dec.instr_ready = 1'b1;
      HRESETn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cyc(1);
         check("t1_addr", bus.HADDR, 32'((k - 1) * 4));
         check("t1_trans", 32'(bus.HTRANS),
               32'((k == 1) ? 2'b10 : SEQ_EXP));
         if (k >= 3) begin
            check("t1_valid", 32'(dec.instr_valid), 32'h1);
            check("t1_pc", dec.instr_pc, 32'((k - 3) * 4));
            check("t1_data", dec.instr_data, exp_word(32'((k - 3) * 4)));
         end else begin
            check("t1_nvalid", 32'(dec.instr_valid), 32'h0);
         end
      end

      // Asynchronous reset in the middle of the stream.
      HRESETn = 1'b0;
      #1;
      chk_reset("async");

      // Back-pressure fills the buffer; one pop releases one fetch.
      hold_reset();
      HRESETn = 1'b1;
      cyc(10);
      check("t2_naddr", 32'(n_addr), 32'd4);
      check("t2_idle", 32'(bus.HTRANS), 32'h0);
      check("t2_pc", dec.instr_pc, 32'h0);
      dec.instr_ready = 1'b1;
      cyc(1);
      dec.instr_ready = 1'b0;
      cyc(8);
      check("t2_naddr1", 32'(n_addr), 32'd5);
      check("t2_idle1", 32'(bus.HTRANS), 32'h0);
      check("t2_pc1", dec.instr_pc, 32'h4);
      check("t2_data1", dec.instr_data, 32'h22);

      // Redirects during a stalled data phase; last target wins.
      hold_reset();
      dec.instr_ready = 1'b1;
      HRESETn = 1'b1;
      cyc(3);
      stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h20;
      cyc(1);
      check("t3_hold_a", bus.HADDR, 32'h8);
      check("t3_hold_t", 32'(bus.HTRANS), 32'(SEQ_EXP));
      check("t3_flush", 32'(dec.instr_valid), 32'h0);
      redirect_pc = 32'h43;
      cyc(1);
      check("t3_hold_a2", bus.HADDR, 32'h8);
      redirect_valid = 1'b0;
      stall = 1'b0;
      cyc(1);
      check("t3_tgt_a", bus.HADDR, 32'h40);
      check("t3_tgt_t", 32'(bus.HTRANS), 32'h2);
      check("t3_nv0", 32'(dec.instr_valid), 32'h0);
      cyc(1);
      check("t3_nv1", 32'(dec.instr_valid), 32'h0);
      check("t3_next_a", bus.HADDR, 32'h44);
      cyc(1);
      check("t3_valid", 32'(dec.instr_valid), 32'h1);
      check("t3_pc", dec.instr_pc, 32'h40);
      check("t3_data", dec.instr_data, exp_word(32'h40));
      cyc(1);
      check("t3_pc2", dec.instr_pc, 32'h44);

      // Error response on 0x8 halts fetch; buffered words survive.
      hold_reset();
      err_en = 1'b1;
      err_addr = 32'h8;
      HRESETn = 1'b1;
      cyc(4);
      check("t4_noerr", 32'(fetch_err), 32'h0);
      cyc(1);
      check("t4_err", 32'(fetch_err), 32'h1);
      check("t4_idle", 32'(bus.HTRANS), 32'h0);
      cyc(1);
      check("t4_pulse", 32'(fetch_err), 32'h0);
      cyc(5);
      check("t4_naddr", 32'(n_addr), 32'd4);
      check("t4_idle2", 32'(bus.HTRANS), 32'h0);
      check("t4_pc0", dec.instr_pc, 32'h0);
      check("t4_d0", dec.instr_data, 32'h11);
      dec.instr_ready = 1'b1;
      cyc(1);
      check("t4_v4", 32'(dec.instr_valid), 32'h1);
      check("t4_pc4", dec.instr_pc, 32'h4);
      check("t4_d4", dec.instr_data, 32'h22);
      cyc(1);
      dec.instr_ready = 1'b0;
      check("t4_empty", 32'(dec.instr_valid), 32'h0);
      err_en = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0;
      cyc(1);
      redirect_valid = 1'b0;
      check("t4_re_a", bus.HADDR, 32'h0);
      check("t4_re_t", 32'(bus.HTRANS), 32'h2);
      cyc(2);
      check("t4_re_v", 32'(dec.instr_valid), 32'h1);
      check("t4_re_pc", dec.instr_pc, 32'h0);

      // Redirect near the top of the address space wraps to zero.
      dec.instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      cyc(1);
      redirect_valid = 1'b0;
      check("t5_top_a", bus.HADDR, 32'hFFFF_FFFC);
      check("t5_top_t", 32'(bus.HTRANS), 32'h2);
      check("t5_flush", 32'(dec.instr_valid), 32'h0);
      cyc(1);
      check("t5_wrap_a", bus.HADDR, 32'h0);
      cyc(1);
      check("t5_pc", dec.instr_pc, 32'hFFFF_FFFC);
      check("t5_data", dec.instr_data, exp_word(32'hFFFF_FFFC));
      cyc(1);
      check("t5_pc0", dec.instr_pc, 32'h0);
      check("t5_d0", dec.instr_data, 32'h11);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
